// File: rtl/data_cache_hit_check_reg.sv
// Registered tag compare for one cache read port: hit/one-hot way/data/victim, 1-cycle latency.
// stall_i freezes results, counters and round-robin pointer; clear_cnt_i acts regardless of stall_i.
module data_cache_hit_check_reg #(
    parameter int WAYS_NUMBER = 4,
    parameter int PORT_WIDTH  = 32,
    parameter int TAG_SIZE    = 20,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              lookup_i,
    input  logic                              stall_i,
    input  logic [WAYS_NUMBER*PORT_WIDTH-1:0] cache_data_i,
    input  logic [WAYS_NUMBER*TAG_SIZE-1:0]   cache_tag_i,
    input  logic [WAYS_NUMBER-1:0]            cache_valid_i,
    input  logic [TAG_SIZE-1:0]               address_tag_i,
    input  logic                              clear_cnt_i,
    output logic                              valid_o,
    output logic                              hit_o,
    output logic                              multi_hit_o,
    output logic [WAYS_NUMBER-1:0]            hit_way_o,
    output logic [PORT_WIDTH-1:0]             cache_data_o,
    output logic [$clog2(WAYS_NUMBER)-1:0]    victim_way_o,
    output logic [CNT_WIDTH-1:0]              hit_count_o,
    output logic [CNT_WIDTH-1:0]              miss_count_o
);
    localparam int WAY_ADDR = $clog2(WAYS_NUMBER);

    logic [WAYS_NUMBER-1:0] way_hit;
    logic [WAY_ADDR:0]      hit_cnt;
    logic                   any_hit;
    logic                   many_hit;
    logic [WAYS_NUMBER-1:0] sel_way;
    logic [PORT_WIDTH-1:0]  sel_data;
    logic [WAY_ADDR-1:0]    victim;
    logic                   all_valid;
    logic [WAY_ADDR-1:0]    rr_ptr;
    logic                   accept;

    // Downward scans so the lowest-index way is the last one assigned.
    always_comb begin
        way_hit  = '0;
        hit_cnt  = '0;
        sel_way  = '0;
        sel_data = '0;
        victim   = rr_ptr;
        for (int i = 0; i < WAYS_NUMBER; i++) begin
            way_hit[i] = cache_valid_i[i] &&
                         (cache_tag_i[i*TAG_SIZE +: TAG_SIZE] == address_tag_i);
            hit_cnt    = hit_cnt + {{WAY_ADDR{1'b0}}, way_hit[i]};
        end
        for (int i = WAYS_NUMBER - 1; i >= 0; i--) begin
            if (way_hit[i]) begin
                sel_way    = '0;
                sel_way[i] = 1'b1;
                sel_data   = cache_data_i[i*PORT_WIDTH +: PORT_WIDTH];
            end
            if (!cache_valid_i[i]) begin
                victim = WAY_ADDR'(i);
            end
        end
        any_hit   = |way_hit;
        many_hit  = (hit_cnt > {{WAY_ADDR{1'b0}}, 1'b1});
        all_valid = &cache_valid_i;
        accept    = lookup_i && !stall_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o      <= 1'b0;
            hit_o        <= 1'b0;
            multi_hit_o  <= 1'b0;
            hit_way_o    <= '0;
            cache_data_o <= '0;
            victim_way_o <= '0;
            hit_count_o  <= '0;
            miss_count_o <= '0;
            rr_ptr       <= '0;
        end else begin
            if (!stall_i) begin
                valid_o <= lookup_i;
            end
            if (accept) begin
                hit_o        <= any_hit;
                multi_hit_o  <= many_hit;
                hit_way_o    <= sel_way;
                cache_data_o <= sel_data;
                victim_way_o <= victim;
                if (!any_hit && all_valid) begin
                    rr_ptr <= rr_ptr + WAY_ADDR'(1);
                end
            end
            if (clear_cnt_i) begin
                hit_count_o  <= '0;
                miss_count_o <= '0;
            end else if (accept) begin
                if (any_hit && !(&hit_count_o)) begin
                    hit_count_o <= hit_count_o + CNT_WIDTH'(1);
                end
                if (!any_hit && !(&miss_count_o)) begin
                    miss_count_o <= miss_count_o + CNT_WIDTH'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_data_cache_hit_check_reg.sv
// Bench for data_cache_hit_check_reg: directed scenarios then randomized traffic vs a reference model.
module tb_data_cache_hit_check_reg;
    localparam int W  = 4;
    localparam int PW = 32;
    localparam int TS = 20;
    localparam int CW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, lookup, stall, clear;
    logic [W-1:0]    valid;
    logic [TS-1:0]   tag [W];
    logic [PW-1:0]   dat [W];
    logic [TS-1:0]   atag;
    logic [W*PW-1:0] cache_data;
    logic [W*TS-1:0] cache_tag;

    logic            valid_o, hit_o, multi_o;
    logic [W-1:0]    way_o;
    logic [PW-1:0]   data_o;
    logic [1:0]      victim_o;
    logic [CW-1:0]   hc_o, mc_o;

    always_comb begin
        cache_data = '0;
        cache_tag  = '0;
        for (int i = 0; i < W; i++) begin
            cache_data[i*PW +: PW] = dat[i];
            cache_tag[i*TS +: TS]  = tag[i];
        end
    end

    data_cache_hit_check_reg #(.WAYS_NUMBER(W), .PORT_WIDTH(PW), .TAG_SIZE(TS), .CNT_WIDTH(CW)) dut (
        .clk_i(clk), .rst_i(rst), .lookup_i(lookup), .stall_i(stall),
        .cache_data_i(cache_data), .cache_tag_i(cache_tag), .cache_valid_i(valid),
        .address_tag_i(atag), .clear_cnt_i(clear),
        .valid_o(valid_o), .hit_o(hit_o), .multi_hit_o(multi_o), .hit_way_o(way_o),
        .cache_data_o(data_o), .victim_way_o(victim_o),
        .hit_count_o(hc_o), .miss_count_o(mc_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    logic          m_valid, m_hit, m_multi;
    logic [W-1:0]  m_way;
    logic [PW-1:0] m_data;
    int            m_victim, m_ptr, m_hc, m_mc;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_hit = 0; m_multi = 0; m_way = '0; m_data = '0;
        m_victim = 0; m_ptr = 0; m_hc = 0; m_mc = 0;
    endtask

    task automatic step(input logic lk, input logic st, input logic cl, input logic rs);
        int nh, first, inv;
        lookup = lk; stall = st; clear = cl; rst = rs;
        nh = 0; first = -1; inv = -1;
        for (int i = 0; i < W; i++) begin
            if (valid[i] && tag[i] == atag) begin
                nh++;
                if (first < 0) first = i;
            end
            if (!valid[i] && inv < 0) inv = i;
        end
        if (rs) begin
            model_reset();
        end else begin
            if (!st) begin
                m_valid = lk;
                if (lk) begin
                    m_hit    = (nh > 0);
                    m_multi  = (nh > 1);
                    m_way    = (first >= 0) ? (W'(1) << first) : '0;
                    m_data   = (first >= 0) ? dat[first] : '0;
                    m_victim = (inv >= 0) ? inv : m_ptr;
                    if (nh == 0 && inv < 0) m_ptr = (m_ptr + 1) % W;
                end
            end
            if (cl) begin
                m_hc = 0; m_mc = 0;
            end else if (lk && !st) begin
                if (nh > 0) m_hc = (m_hc < 15) ? m_hc + 1 : 15;
                else        m_mc = (m_mc < 15) ? m_mc + 1 : 15;
            end
        end
        @(posedge clk);
        #1;
        chk("valid", 64'(valid_o), 64'(m_valid));
        chk("hit", 64'(hit_o), 64'(m_hit));
        chk("multi_hit", 64'(multi_o), 64'(m_multi));
        chk("hit_way", 64'(way_o), 64'(m_way));
        chk("data", 64'(data_o), 64'(m_data));
        chk("victim", 64'(victim_o), 64'(m_victim));
        chk("hit_count", 64'(hc_o), 64'(m_hc));
        chk("miss_count", 64'(mc_o), 64'(m_mc));
    endtask

    task automatic set_all_miss();
        valid = 4'hF;
        for (int i = 0; i < W; i++) begin
            tag[i] = TS'(20'hA0000 + i);
            dat[i] = $urandom;
        end
        atag = 20'h55555;
    endtask

    initial begin
        logic [CW-1:0] frozen_hc, frozen_mc;
        rst = 1; lookup = 0; stall = 0; clear = 0; atag = '0; valid = '0;
        for (int i = 0; i < W; i++) begin tag[i] = '0; dat[i] = '0; end
        model_reset();

        // Reset state
        step(0, 0, 0, 1);
        chk("reset_valid", 64'(valid_o), 64'(0));
        chk("reset_hc", 64'(hc_o), 64'(0));

        // Single hit on way 2
        set_all_miss();
        valid = 4'b0100; tag[2] = 20'h12345; dat[2] = 32'hCAFEF00D; atag = 20'h12345;
        step(1, 0, 0, 0);
        chk("t1_way", 64'(way_o), 64'(4'b0100));
        chk("t1_data", 64'(data_o), 64'(32'hCAFEF00D));
        chk("t1_hc", 64'(hc_o), 64'(1));

        // Multi-hit on ways 1 and 3
        set_all_miss();
        valid = 4'b1010; tag[1] = 20'h00777; tag[3] = 20'h00777; atag = 20'h00777;
        step(1, 0, 0, 0);
        chk("t2_way", 64'(way_o), 64'(4'b0010));
        chk("t2_multi", 64'(multi_o), 64'(1));
        chk("t2_data", 64'(data_o), 64'(dat[1]));

        // Round-robin victim on full-valid misses
        set_all_miss();
        for (int k = 0; k < 5; k++) begin
            step(1, 0, 0, 0);
            chk("t3_victim", 64'(victim_o), 64'(k % 4));
        end
        chk("t3_mc", 64'(mc_o), 64'(5));

        // Invalid way wins; pointer untouched
        valid = 4'b1011;
        step(1, 0, 0, 0);
        chk("t4_victim_inv", 64'(victim_o), 64'(2));
        valid = 4'hF;
        step(1, 0, 0, 0);
        chk("t4_victim_rr", 64'(victim_o), 64'(1));

        // Stall freezes everything
        frozen_hc = hc_o; frozen_mc = mc_o;
        for (int k = 0; k < 3; k++) begin
            atag = TS'(k);
            tag[0] = TS'(k);
            step(1, 1, 0, 0);
        end
        chk("t5_frozen_mc", 64'(mc_o), 64'(frozen_mc));
        step(1, 0, 0, 0);
        chk("t5_one_hit", 64'(hc_o), 64'(frozen_hc + 1'b1));
        step(0, 0, 0, 0);
        chk("t5_idle_valid", 64'(valid_o), 64'(0));

        // Saturation, clear-with-hit, clear under stall, mid-stream reset
        for (int k = 0; k < 16; k++) step(1, 0, 0, 0);
        chk("t6_sat", 64'(hc_o), 64'(4'hF));
        step(1, 0, 1, 0);
        chk("t6_clear", 64'(hc_o), 64'(0));
        step(1, 0, 0, 0);
        step(1, 1, 1, 0);
        chk("t6_clear_stall", 64'(hc_o), 64'(0));
        step(1, 0, 0, 0);
        step(1, 0, 0, 1);
        chk("t6_rst_hit", 64'(hit_o), 64'(0));

        // Randomized traffic from a small tag alphabet
        for (int n = 0; n < 600; n++) begin
            valid = 4'($urandom);
            for (int i = 0; i < W; i++) begin
                tag[i] = TS'($urandom_range(0, 3));
                dat[i] = $urandom;
            end
            atag = TS'($urandom_range(0, 3));
            step(($urandom_range(0, 9) < 7), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 29) == 0), ($urandom_range(0, 99) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
